// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state type and constants (PARITY state only with UART_RX_PARITY_EN)
package uart_pkg;

  localparam int   DEFAULT_DATA_BITS = 8;
  localparam logic IDLE_LEVEL        = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receiver result bus: received data, status pulses and busy
interface uart_rx_if #(
  parameter int DATA_BITS = uart_pkg::DEFAULT_DATA_BITS
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (output rx_data, rx_valid, frame_err, parity_err, busy);
  modport slave  (input  rx_data, rx_valid, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line, resets to the idle level
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta     <= IDLE_LEVEL;
      sync_out <= IDLE_LEVEL;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, mid-bit sampling, LSB first; UART_RX_PARITY_EN adds an even-parity bit
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master rx_out
);

  localparam int                CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int                BW        = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0]     BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]     BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]     BIT_LAST  = BW'(DATA_BITS - 1);

  uart_state_t          state;
  uart_state_t          next_state;
  logic                 rx_s;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 parity_err_q;

  logic                 baud_tick;
  logic                 half_tick;
  logic                 shift_en;
  logic                 stop_sample;
  logic                 load_c;
  logic                 ferr_c;
  logic                 perr_c;
  logic                 busy_c;

`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`endif

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (rx),
    .sync_out (rx_s)
  );

  assign baud_tick = (baud_cnt == BAUD_LAST);
  assign half_tick = (state == START) && (baud_cnt == BAUD_HALF);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (rx_s != IDLE_LEVEL) next_state = START;
      START:  if (half_tick) next_state = (rx_s == IDLE_LEVEL) ? IDLE : DATA;
      DATA:   if (baud_tick && (bit_cnt == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
                next_state = PARITY;
`else
                next_state = STOP;
`endif
              end
`ifdef UART_RX_PARITY_EN
      PARITY: if (baud_tick) next_state = STOP;
`endif
      STOP:   if (baud_tick) next_state = (rx_s == IDLE_LEVEL) ? IDLE : BREAK;
      BREAK:  if (rx_s == IDLE_LEVEL) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes decided here are registered below, so every pulse lands one edge after its sample.
  always_comb begin
    busy_c      = (state != IDLE) && !rst;
    shift_en    = (state == DATA) && baud_tick;
    stop_sample = (state == STOP) && baud_tick;
    ferr_c      = stop_sample && (rx_s != IDLE_LEVEL);
`ifdef UART_RX_PARITY_EN
    perr_c      = stop_sample && par_bad;
    load_c      = stop_sample && (rx_s == IDLE_LEVEL) && !par_bad;
`else
    perr_c      = 1'b0;
    load_c      = stop_sample && (rx_s == IDLE_LEVEL);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      rx_valid_q   <= load_c;
      frame_err_q  <= ferr_c;
      parity_err_q <= perr_c;

      if (load_c) begin
        rx_data_q <= shreg;
      end

      if ((state == IDLE) || (state == BREAK) || half_tick || baud_tick) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end

      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + BW'(1);
      end

      if (shift_en) begin
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data ones plus the parity bit must total an even count.
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE)) begin
      par_bad <= 1'b0;
    end else if ((state == PARITY) && baud_tick) begin
      par_bad <= (^shreg) ^ rx_s;
    end
  end
`endif

  assign rx_out.rx_data    = rx_data_q;
  assign rx_out.rx_valid   = rx_valid_q;
  assign rx_out.frame_err  = frame_err_q;
  assign rx_out.parity_err = parity_err_q;
  assign rx_out.busy       = busy_c;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx; parity cases run when UART_RX_PARITY_EN is defined
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;
  localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PB  = 1;
`else
  localparam int PB  = 0;
`endif
  localparam int FRAME = CPB * (DB + 2 + PB);

  localparam logic [2:0] K_VALID = 3'b100;
  localparam logic [2:0] K_FERR  = 3'b010;
  localparam logic [2:0] K_PERR  = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BITS(DB)) rxif ();

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .rx_out (rxif)
  );

  typedef struct packed {
    logic [2:0]    kind;
    logic [DB-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   valid_cycles[$];
  int   passed = 0;
  int   total  = 0;
  int   cycle  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Monitor: every status pulse is matched against the oldest expected event.
  always @(negedge clk) begin
    if (rxif.rx_valid || rxif.frame_err || rxif.parity_err) begin
      if (rxif.rx_valid) valid_cycles.push_back(cycle);
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_pulse: got kind %b data 0x%0h, required no pulse",
                 {rxif.rx_valid, rxif.frame_err, rxif.parity_err}, rxif.rx_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", {29'd0, rxif.rx_valid, rxif.frame_err, rxif.parity_err}, {29'd0, mon_e.kind});
        check("pulse_data", {24'd0, rxif.rx_data}, {24'd0, mon_e.data});
      end
    end
  end

  task automatic expect_ev(input logic [2:0] kind, input logic [DB-1:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DB-1:0] data, input logic stop, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(data[i]);
    if (PB != 0) send_bit((^data) ^ par_flip);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 4 * CPB && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check({"drain_", name}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_data",    {24'd0, rxif.rx_data}, 32'h0);
    check("rst_rx_valid",   {31'd0, rxif.rx_valid}, 32'h0);
    check("rst_frame_err",  {31'd0, rxif.frame_err}, 32'h0);
    check("rst_parity_err", {31'd0, rxif.parity_err}, 32'h0);
    check("rst_busy",       {31'd0, rxif.busy}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);

    expect_ev(K_VALID, 8'h55);
    send_frame(8'h55, 1'b1, 1'b0);
    drain("frame_55");
    check("idle_after_55", {31'd0, rxif.busy}, 32'h0);

    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("false_start_busy", {31'd0, rxif.busy}, 32'h0);
    check("false_start_data", {24'd0, rxif.rx_data}, 32'h55);
    idle(CPB);

    expect_ev(K_FERR, 8'h55);
    send_frame(8'hA3, 1'b0, 1'b0);
    repeat (40 - CPB) @(posedge clk);
    #1;
    drain("frame_a3_break");
    check("break_busy_high", {31'd0, rxif.busy}, 32'h1);
    check("break_data_kept", {24'd0, rxif.rx_data}, 32'h55);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("break_exit_busy", {31'd0, rxif.busy}, 32'h0);
    idle(CPB);

    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_busy", {31'd0, rxif.busy}, 32'h0);
    check("mid_rst_data", {24'd0, rxif.rx_data}, 32'h0);
    rst = 1'b0;
    idle(2 * CPB);
    expect_ev(K_VALID, 8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    drain("frame_3c");

    idle(CPB);
    valid_cycles.delete();
    expect_ev(K_VALID, 8'h00);
    expect_ev(K_VALID, 8'hFF);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    drain("back_to_back");
    check("b2b_count", valid_cycles.size(), 2);
    if (valid_cycles.size() == 2)
      check("b2b_spacing", valid_cycles[1] - valid_cycles[0], FRAME);

`ifdef UART_RX_PARITY_EN
    idle(CPB);
    expect_ev(K_PERR, 8'hFF);
    send_frame(8'h07, 1'b1, 1'b1);
    drain("parity_bad_07");
    idle(CPB);
    expect_ev(K_VALID, 8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    drain("parity_good_07");
`endif

    idle(3 * CPB);
    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; minimum 4.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rx  input  1  serial line, asynchronous to clk, idle high.
REQ-006 SHALL have port rx_data  output  DATA_BITS  last correctly received byte.
REQ-007 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data is updated.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse when a stop bit is bad.
REQ-009 SHALL have port parity_err  output  1  one-cycle pulse when parity is bad.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-012 SHALL implement the states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-013 IDLE: when rx_s is 0, SHALL go to START and clear the bit counter.
REQ-014 START: after CLKS_PER_BIT/2 cycles, SHALL sample rx_s; 0 goes to DATA; 1 is a false start and returns to IDLE with no pulse.
REQ-015 DATA: SHALL sample every CLKS_PER_BIT cycles, LSB first, shifting into the shift register; after DATA_BITS samples, SHALL go to PARITY if enabled, otherwise STOP.
REQ-016 STOP: SHALL sample CLKS_PER_BIT cycles after the last data or parity sample.
REQ-017 On a stop sample of 1 with no parity error, SHALL load rx_data and pulse rx_valid on the next clk edge, then go to IDLE.
REQ-018 On a stop sample of 0, SHALL pulse frame_err, leave rx_data unchanged, and go to BREAK.
REQ-019 BREAK: SHALL stay until rx_s is 1, then go to IDLE.
REQ-020 Latency SHALL be a rx_valid rise 1 cycle after the stop-bit mid-sample; back-to-back frames with no idle gap SHALL be received.
REQ-021 rx_valid, frame_err and parity_err SHALL never be asserted in the same cycle, except that frame_err and parity_err may coincide.
REQ-022 rx_data SHALL hold its value until the next valid frame.
REQ-023 The baud counter SHALL be width $clog2(CLKS_PER_BIT) and SHALL wrap to 0 at CLKS_PER_BIT-1.

Reset
REQ-024 While rst is high, SHALL force state to IDLE, all counters to 0, and the synchronizer flops to 1.
REQ-025 While rst is high, SHALL force rx_data to 0 and rx_valid, frame_err, parity_err and busy to 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no pulse; the first full frame after release SHALL be received normally.

Configuration
REQ-027 With macro UART_RX_PARITY_EN defined, SHALL insert the PARITY state: sample one even-parity bit; on mismatch, pulse parity_err at the stop-sample time and suppress rx_valid.
REQ-028 Without UART_RX_PARITY_EN, the PARITY state and its logic SHALL be absent and parity_err SHALL be tied to 0.

Structure
REQ-029 Package uart_pkg SHALL hold the state enum type uart_state_t, the default DATA_BITS constant and the IDLE_LEVEL constant (1), shared with the transmitter.
REQ-030 The synchronizer SHALL be a separate sub-module, uart_rx_sync, with clk, rst, async input and sync output; all other logic is in uart_rx.

Verification (CLKS_PER_BIT=16)
REQ-031 Frame 0x55 with a good stop bit -> exactly one rx_valid pulse, rx_data=0x55, frame_err=0.
REQ-032 rx low for 4 cycles then high -> no pulse, busy returns to 0 within 8 cycles.
REQ-033 Frame 0xA3 with stop bit 0 held 40 cycles -> one frame_err pulse, rx_data keeps its previous value, and busy stays high until rx returns high.
REQ-034 rst pulsed mid-DATA of 0x12, then frame 0x3C -> no pulse for 0x12; rx_valid with rx_data=0x3C.
REQ-035 Back-to-back 0x00 then 0xFF with no gap -> two rx_valid pulses 160 cycles apart, with the correct data for each.
REQ-036 With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 -> parity_err pulse and no rx_valid; with parity bit 1 -> rx_valid and rx_data=0x07.
